ov7670_sccb_sequencer: RTL and testbench

Configuration controller for the OV7670 camera. Walks the camera register table (16-bit `{reg, value}` words, terminated by `16'hFFFF`) and turns each entry into an SCCB 3-phase write on SIOC/SIOD. It enforces a settle delay after any soft reset (COM7 bit 7) and flags when the sensor is fully configured. Sits between the register-table ROM (`resend`/`advance`/`command`/`finished`) and the camera pins, in the camera clock domain.

---
 rtl/ov7670_sccb_sequencer.sv | 177 +++++++++++++++++
 tb/tb_ov7670_sccb_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_sequencer.sv
// ============================================================================
// Module   : ov7670_sccb_sequencer
// Function : Walks the OV7670 register table and issues one SCCB 3-phase write
//            per entry, with a settle delay after COM7 soft resets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov7670_sccb_sequencer #(
    parameter int         DIV           = 125,
    parameter int         SETTLE_CYCLES = 50000,
    parameter logic [7:0] DEV_ADDR      = 8'h42
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] command,
    input  logic        finished,
    output logic        resend,
    output logic        advance,
    output logic        sioc,
    output logic        siod_o,
    output logic        siod_oe,
    output logic        busy,
    output logic        config_done
);

    localparam int             c_QW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int             c_SW         = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_QW-1:0] c_Q_LAST     = c_QW'(DIV - 1);
    localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(SETTLE_CYCLES - 1);
    localparam logic [c_SW-1:0] c_FETCH_LAST = c_SW'(1);
    localparam logic [4:0]      c_BIT_LAST   = 5'd26;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_REWIND = 4'd1,
        S_FETCH  = 4'd2,
        S_START  = 4'd3,
        S_BITS   = 4'd4,
        S_STOP   = 4'd5,
        S_GAP    = 4'd6,
        S_CHECK  = 4'd7,
        S_SETTLE = 4'd8,
        S_NEXT   = 4'd9,
        S_DONE   = 4'd10
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_auto;
    logic [c_QW-1:0] r_q;
    logic [1:0]      r_ph;
    logic [4:0]      r_bit;
    logic [c_SW-1:0] r_wait;
    logic [15:0]     r_cmd;
    logic            r_busy;
    logic            r_done;

    logic            w_q_last;
    logic            w_slot_last;
    logic            w_rel;
    logic            w_bitval;
    logic [26:0]     w_frame;

    assign w_q_last    = (r_q == c_Q_LAST);
    assign w_slot_last = w_q_last && (r_ph == 2'd3);
    // Each 9-bit phase ends with a released ACK slot.
    assign w_frame     = {DEV_ADDR, 1'b1, r_cmd[15:8], 1'b1, r_cmd[7:0], 1'b1};
    assign w_rel       = (r_bit == 5'd8) || (r_bit == 5'd17) || (r_bit == 5'd26);
    assign w_bitval    = w_frame[c_BIT_LAST - r_bit];

    assign busy        = r_busy;
    assign config_done = r_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_auto  <= 1'b1;
            r_q     <= '0;
            r_ph    <= '0;
            r_bit   <= '0;
            r_wait  <= '0;
            r_cmd   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE) begin
                r_auto <= 1'b0;
            end
            if (r_state == S_REWIND) begin
                r_busy <= 1'b1;
                r_done <= 1'b0;
            end
            if (r_state == S_DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (r_state == S_FETCH && w_next == S_START) begin
                r_cmd <= command;
            end

            // Quarter-bit timing restarts on every state change.
            if (r_state != w_next || w_q_last) begin
                r_q <= '0;
            end else begin
                r_q <= r_q + 1'b1;
            end
            if (r_state != w_next) begin
                r_ph <= '0;
            end else if (w_q_last) begin
                r_ph <= r_ph + 1'b1;
            end

            if (r_state != S_BITS) begin
                r_bit <= '0;
            end else if (w_slot_last && r_bit != c_BIT_LAST) begin
                r_bit <= r_bit + 1'b1;
            end

            if (r_state != w_next) begin
                r_wait <= '0;
            end else if (r_state == S_FETCH || r_state == S_SETTLE) begin
                r_wait <= r_wait + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start || r_auto) w_next = S_REWIND;
            S_REWIND: w_next = S_FETCH;
            S_FETCH:  if (r_wait == c_FETCH_LAST) w_next = finished ? S_DONE : S_START;
            S_START:  if (w_slot_last) w_next = S_BITS;
            S_BITS:   if (w_slot_last && r_bit == c_BIT_LAST) w_next = S_STOP;
            S_STOP:   if (w_slot_last) w_next = S_GAP;
            S_GAP:    if (w_slot_last) w_next = S_CHECK;
            S_CHECK:  w_next = (r_cmd[15:8] == 8'h12 && r_cmd[7]) ? S_SETTLE : S_NEXT;
            S_SETTLE: if (r_wait == c_SETTLE_LAST) w_next = S_NEXT;
            S_NEXT:   w_next = S_FETCH;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        resend  = 1'b0;
        advance = 1'b0;
        sioc    = 1'b1;
        siod_o  = 1'b1;
        siod_oe = 1'b0;
        case (r_state)
            S_REWIND: resend = 1'b1;
            S_NEXT:   advance = 1'b1;
            S_START: begin
                siod_oe = 1'b1;
                siod_o  = ~r_ph[1];
            end
            S_BITS: begin
                sioc    = r_ph[1];
                siod_oe = ~w_rel;
                siod_o  = w_rel ? 1'b1 : w_bitval;
            end
            S_STOP: begin
                sioc    = (r_ph != 2'd0);
                siod_o  = r_ph[1];
                siod_oe = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_ov7670_sccb_sequencer.sv
// ============================================================================
// Module   : tb_ov7670_sccb_sequencer
// Function : Randomized register table, bus-level frame decoder and timing
//            model for ov7670_sccb_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ov7670_sccb_sequencer;

    localparam int D      = 2;
    localparam int S      = 10;
    localparam int N_ENT  = 56;
    localparam int TO_RUN = 20000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] command = 16'hFFFF;
    logic        finished;
    logic        resend, advance, sioc, siod_o, siod_oe, busy, config_done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] tbl [N_ENT];
    int          rom_addr = 0;

    ov7670_sccb_sequencer #(
        .DIV          (D),
        .SETTLE_CYCLES(S),
        .DEV_ADDR     (8'h42)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .command    (command),
        .finished   (finished),
        .resend     (resend),
        .advance    (advance),
        .sioc       (sioc),
        .siod_o     (siod_o),
        .siod_oe    (siod_oe),
        .busy       (busy),
        .config_done(config_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ent(input int i);
        return (i >= 0 && i < N_ENT) ? tbl[i] : 16'hFFFF;
    endfunction

    function automatic int settle_of(input logic [15:0] e);
        return (e[15:8] == 8'h12 && e[7]) ? S : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Registered table ROM: entry appears two cycles after resend/advance.
    always @(posedge clk) begin
        if (resend)       rom_addr <= 0;
        else if (advance) rom_addr <= rom_addr + 1;
        command <= ent(rom_addr);
    end
    assign finished = (command == 16'hFFFF);

    // Bus monitor: decodes START/bits/STOP and checks frame content and timing.
    int          cyc = 0, n_adv = 0, n_rsd = 0, n_frames = 0, exp_idx = 0;
    int          bitcnt = 0, last_pulse = 0, last_stop = 0;
    bit          in_frame = 0, pulse_ok = 0, stop_ok = 0;
    logic        pv_sioc = 1'b1, pv_sd = 1'b1, sd;
    logic [26:0] bits, oes;
    logic [15:0] last_frame = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            sd = siod_oe ? siod_o : 1'b1;
            if (reset) begin
                in_frame = 0;
                pulse_ok = 0;
                stop_ok  = 0;
                sd       = 1'b1;
            end else begin
                if (resend) begin
                    n_rsd++;
                    exp_idx    = 0;
                    last_pulse = cyc;
                    pulse_ok   = 1;
                    stop_ok    = 0;
                end
                if (advance) begin
                    if (pulse_ok) chk("adv_period", cyc - last_pulse, 4 + 120 * D + settle_of(ent(exp_idx)));
                    if (stop_ok)  chk("stop_to_adv", cyc - last_stop, 6 * D + 1 + settle_of(ent(exp_idx)));
                    n_adv++;
                    exp_idx++;
                    last_pulse = cyc;
                    pulse_ok   = 1;
                    stop_ok    = 0;
                end
                if (pv_sioc && sioc && pv_sd && !sd) begin
                    in_frame = 1;
                    bitcnt   = 0;
                end else if (!pv_sioc && sioc && in_frame && bitcnt < 27) begin
                    bits[26 - bitcnt] = sd;
                    oes[26 - bitcnt]  = siod_oe;
                    bitcnt++;
                end else if (pv_sioc && sioc && !pv_sd && sd && in_frame) begin
                    chk("frame_len", bitcnt, 27);
                    chk("frame_data", {8'h0, bits[26:19], bits[17:10], bits[8:1]},
                        {8'h0, 8'h42, ent(exp_idx)});
                    chk("ack_release", {5'h0, oes},
                        {5'h0, ~((27'd1 << 18) | (27'd1 << 9) | 27'd1)});
                    last_frame = {bits[17:10], bits[8:1]};
                    n_frames++;
                    last_stop = cyc;
                    stop_ok   = 1;
                    in_frame  = 0;
                end
            end
            pv_sioc = reset ? 1'b1 : sioc;
            pv_sd   = sd;
        end
    end

    task automatic wait_done(input string tag);
        int n = 0;
        while (!config_done && n < TO_RUN) begin
            @(negedge clk);
            n++;
        end
        chk(tag, config_done, 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    initial begin
        int b_adv, b_rsd, b_frm, n;

        tbl[0] = 16'h1280;
        tbl[1] = 16'h1280;
        tbl[2] = 16'h1204;
        for (int i = 3; i < N_ENT - 1; i++) begin
            tbl[i] = 16'($urandom);
            if (tbl[i] == 16'hFFFF) tbl[i] = 16'hFFFE;
        end
        tbl[N_ENT - 1] = 16'hB80A;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_sioc", sioc, 1'b1);
        chk("rst_siod_o", siod_o, 1'b1);
        chk("rst_siod_oe", siod_oe, 1'b0);
        chk("rst_resend", resend, 1'b0);
        chk("rst_advance", advance, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", config_done, 1'b0);
        reset = 1'b0;

        // Automatic first run over the whole table
        wait_done("run1_done");
        @(negedge clk);
        chk("run1_resends", n_rsd, 1);
        chk("run1_advances", n_adv, N_ENT);
        chk("run1_frames", n_frames, N_ENT);
        chk("run1_busy", busy, 1'b0);
        chk("run1_sioc", sioc, 1'b1);
        chk("run1_oe", siod_oe, 1'b0);
        chk("run1_last", last_frame, 16'hB80A);

        // Rerun via start, with a stray start mid-frame
        b_adv = n_adv; b_rsd = n_rsd; b_frm = n_frames;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_resend", resend, 1'b1);
        @(negedge clk);
        chk("start_busy", busy, 1'b1);
        chk("start_done_clr", config_done, 1'b0);
        n = 0;
        while (!(in_frame && bitcnt == 5) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("midframe_reach", n < 2000, 1'b1);
        pulse_start();
        repeat (10) @(negedge clk);
        chk("midframe_no_resend", n_rsd - b_rsd, 1);
        wait_done("run2_done");
        chk("run2_advances", n_adv - b_adv, N_ENT);
        chk("run2_frames", n_frames - b_frm, N_ENT);

        // Reset during bit 13 of a later frame
        b_frm = n_frames; b_rsd = n_rsd;
        pulse_start();
        n = 0;
        while (!(n_frames - b_frm >= 3 && in_frame && bitcnt == 13 && !sioc) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("bit13_reach", n < 4000, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_sioc", sioc, 1'b1);
        chk("abort_oe", siod_oe, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(negedge clk) reset = 1'b0;
        n = 0;
        while (!resend && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("restart_resend", resend, 1'b1);
        b_frm = n_frames;
        n = 0;
        while (n_frames == b_frm && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("restart_frame", last_frame, 16'h1280);
        chk("restart_idx", exp_idx, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
